// File: rtl/clk_div_ctrl.sv
`default_nettype none
// clk_div_ctrl: run-time controller for a registered divided clock.
// Divisor changes and stops take effect only at a period boundary, so clk_out never glitches.
module clk_div_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_done,
  output logic         cfg_err,
  output logic [W-1:0] cur_div,
  output logic         running,
  output logic         tick,
  output logic         clk_out
);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_q, pend_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;

  logic         xfer;
  logic         legal;
  logic         wrap;

  assign cfg_ready = (state_q != ST_SWITCH);
  assign running   = (state_q != ST_STOP);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign cur_div   = div_q;
  assign tick      = tick_q;
  assign clk_out   = clk_q;

  assign xfer  = cfg_valid && cfg_ready;
  assign legal = (cfg_div >= W'(2));
  assign wrap  = (cnt_q == div_q - W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    err_d   = xfer && !legal;

    case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        if (xfer && legal) begin
          div_d  = cfg_div;
          done_d = 1'b1;
        end
        if (en) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        cnt_d = wrap ? '0 : cnt_q + W'(1);
        // A legal transfer outranks a stop request; en is re-sampled at the switch wrap.
        if (xfer && legal) begin
          pend_d  = cfg_div;
          state_d = ST_SWITCH;
        end else if (wrap && !en) begin
          state_d = ST_STOP;
        end
      end

      ST_SWITCH: begin
        cnt_d = wrap ? '0 : cnt_q + W'(1);
        if (wrap) begin
          div_d   = pend_q;
          done_d  = 1'b1;
          state_d = en ? ST_RUN : ST_STOP;
        end
      end

      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase

    // Outputs are computed from next-state values so the flops line up with cnt.
    clk_d  = (state_d != ST_STOP) && (cnt_d < (div_d >> 1));
    tick_d = (state_d != ST_STOP) && (cnt_d == div_d - W'(1));
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      div_q   <= DIV_RST;
      pend_q  <= DIV_RST;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      err_q   <= err_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

endmodule
`default_nettype wire
